gppcu_issue_ctrl: RTL and testbench

//  Parametrised in-order front end for the GPPCU pipeline. It buffers instructions in an

---
 rtl/gppcu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_gppcu_issue_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gppcu_issue_ctrl.sv
// gppcu_issue_ctrl: in-order single-issue front end with instruction FIFO, register scoreboard
// and NSTAGE-deep execute tracker.
// Ports:
//   iACLK, inRST                 clock (rising edge), asynchronous active-low reset
//   iINSTR, iCTRL, iINSTR_VALID  instruction word, {regwr, useb, usea}, push request
//   oINSTR_READY                 FIFO can accept a push this cycle
//   iFLUSH                       discard queued instructions
//   iBUSY                        freeze execute tracker and block issue
//   oISSUE_VALID, oISSUE_INSTR   stage 0 contents
//   oWB_VALID, oWB_REGD, oWB_REGWR  writeback commit from the last stage
//   oSTALL_HAZARD                head instruction blocked by the scoreboard
//   oFIFO_LEVEL                  occupied FIFO entries
//   oIDLE                        nothing queued, in flight or pending
module gppcu_issue_ctrl #(
    parameter int DBW        = 32,
    parameter int NUMREG     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int NSTAGE     = 3,
    parameter int REGD_LSB   = 16,
    parameter int REGA_LSB   = 11,
    parameter int REGB_LSB   = 0
) (
    input  logic                          iACLK,
    input  logic                          inRST,
    input  logic [DBW-1:0]                iINSTR,
    input  logic [2:0]                    iCTRL,
    input  logic                          iINSTR_VALID,
    output logic                          oINSTR_READY,
    input  logic                          iFLUSH,
    input  logic                          iBUSY,
    output logic                          oISSUE_VALID,
    output logic [DBW-1:0]                oISSUE_INSTR,
    output logic                          oWB_VALID,
    output logic [$clog2(NUMREG)-1:0]     oWB_REGD,
    output logic                          oWB_REGWR,
    output logic                          oSTALL_HAZARD,
    output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL,
    output logic                          oIDLE
);
    localparam int RBW = $clog2(NUMREG);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge iACLK or negedge inRST)
        if (!inRST) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    assign rst_n = rst_sync_q[1];

    logic [DBW-1:0]    mem_instr_q [FIFO_DEPTH];
    logic [2:0]        mem_ctrl_q  [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [NUMREG-1:0] pend_q, pend_d, clr_mask, set_mask, pend_eff;
    logic [NSTAGE-1:0] s_vld_q, s_wr_q;
    logic [RBW-1:0]    s_rd_q [NSTAGE];
    logic [DBW-1:0]    iss_instr_q;

    logic           full, head_vld, push, issue, haz;
    logic [DBW-1:0] head_instr;
    logic [2:0]     head_ctrl;
    logic [RBW-1:0] rd, ra, rb;

    assign full       = level_q == LW'(FIFO_DEPTH);
    assign head_vld   = level_q != '0;
    assign head_instr = mem_instr_q[rd_ptr_q];
    assign head_ctrl  = mem_ctrl_q[rd_ptr_q];
    assign rd         = head_instr[REGD_LSB +: RBW];
    assign ra         = head_instr[REGA_LSB +: RBW];
    assign rb         = head_instr[REGB_LSB +: RBW];

    assign oINSTR_READY = ~full & ~iFLUSH;
    assign push         = iINSTR_VALID & oINSTR_READY;

    // A register committing this cycle is already free for the head (writeback bypass).
    assign clr_mask = (oWB_VALID & oWB_REGWR) ? NUMREG'(1) << oWB_REGD : '0;
    assign pend_eff = pend_q & ~clr_mask;
    assign haz      = (head_ctrl[0] & pend_eff[ra]) | (head_ctrl[1] & pend_eff[rb]) |
                      (head_ctrl[2] & pend_eff[rd]);
    assign issue    = head_vld & ~haz & ~iBUSY & ~iFLUSH;
    assign set_mask = (issue & head_ctrl[2]) ? NUMREG'(1) << rd : '0;
    // Set after clear so a same-edge issue to the committing register keeps it pending.
    assign pend_d   = pend_eff | set_mask;

    // Push is refused while full, so no pop-through; flush realigns both pointers.
    assign wr_ptr_d = iFLUSH ? '0 : wr_ptr_q + AW'(push);
    assign rd_ptr_d = iFLUSH ? '0 : rd_ptr_q + AW'(issue);
    assign level_d  = iFLUSH ? '0 : level_q + LW'(push) - LW'(issue);

    always_ff @(posedge iACLK)
        if (push) begin
            mem_instr_q[wr_ptr_q] <= iINSTR;
            mem_ctrl_q[wr_ptr_q]  <= iCTRL;
        end

    always_ff @(posedge iACLK or negedge rst_n)
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pend_q      <= '0;
            s_vld_q     <= '0;
            s_wr_q      <= '0;
            iss_instr_q <= '0;
            for (int i = 0; i < NSTAGE; i++) s_rd_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pend_q   <= pend_d;
            if (issue) iss_instr_q <= head_instr;
            if (!iBUSY) begin
                s_vld_q[0] <= issue;
                s_wr_q[0]  <= issue & head_ctrl[2];
                s_rd_q[0]  <= issue ? rd : '0;
                for (int i = 1; i < NSTAGE; i++) begin
                    s_vld_q[i] <= s_vld_q[i-1];
                    s_wr_q[i]  <= s_wr_q[i-1];
                    s_rd_q[i]  <= s_rd_q[i-1];
                end
            end
        end

    // Busy freezes the last stage, so gating here makes each commit appear exactly once.
    assign oWB_VALID     = s_vld_q[NSTAGE-1] & ~iBUSY;
    assign oWB_REGD      = s_rd_q[NSTAGE-1];
    assign oWB_REGWR     = s_wr_q[NSTAGE-1];
    assign oISSUE_VALID  = s_vld_q[0];
    assign oISSUE_INSTR  = iss_instr_q;
    assign oSTALL_HAZARD = head_vld & haz;
    assign oFIFO_LEVEL   = level_q;
    assign oIDLE         = ~head_vld & ~|s_vld_q & ~|pend_q;
endmodule

// File: tb/tb_gppcu_issue_ctrl.sv
// tb_gppcu_issue_ctrl: directed plus random stimulus checked against a queue-based reference model.
module tb_gppcu_issue_ctrl;
    localparam int NS = 3;
    localparam int FD = 4;

    typedef struct packed {logic [31:0] instr; logic [2:0] ctrl;} ent_t;
    typedef struct packed {logic [4:0] rd; logic wr; int age;} fly_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr = '0;
    logic [2:0]  ctrl = '0;
    logic        vld = 1'b0, flush = 1'b0, busy = 1'b0;
    logic        ready, iss_v, wb_v, wb_wr, stall, idle;
    logic [31:0] iss_instr;
    logic [4:0]  wb_rd;
    logic [2:0]  level;

    ent_t        fifo[$];
    fly_t        fly[$];
    logic [31:0] last_instr = '0;
    int          n_vec = 0, n_err = 0, cyc = 0;

    always #5 clk = ~clk;

    gppcu_issue_ctrl #(.NSTAGE(NS), .FIFO_DEPTH(FD)) dut (
        .iACLK(clk), .inRST(rst_n), .iINSTR(instr), .iCTRL(ctrl), .iINSTR_VALID(vld),
        .oINSTR_READY(ready), .iFLUSH(flush), .iBUSY(busy), .oISSUE_VALID(iss_v),
        .oISSUE_INSTR(iss_instr), .oWB_VALID(wb_v), .oWB_REGD(wb_rd), .oWB_REGWR(wb_wr),
        .oSTALL_HAZARD(stall), .oFIFO_LEVEL(level), .oIDLE(idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int d, input int a, input int b);
        logic [31:0] w;
        w = $urandom;
        w[20:16] = d[4:0];
        w[15:11] = a[4:0];
        w[4:0]   = b[4:0];
        return w;
    endfunction

    // A register is pending while some in-flight writer targets it, unless that writer commits now.
    function automatic bit pending(input logic [4:0] r, input logic b);
        foreach (fly[i])
            if (fly[i].wr && fly[i].rd == r && !(fly[i].age == NS-1 && !b)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        fifo.delete();
        fly.delete();
        last_instr = '0;
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] c,
                        input logic b, input logic f);
        ent_t e;
        bit   hv, hz, iss, psh, rdy, s0;
        int   wi;
        @(negedge clk);
        vld = v; instr = ins; ctrl = c; busy = b; flush = f;
        #1;
        hv = fifo.size() != 0;
        e  = hv ? fifo[0] : '0;
        wi = -1;
        s0 = 0;
        foreach (fly[i]) begin
            if (fly[i].age == NS-1) wi = i;
            if (fly[i].age == 0) s0 = 1;
        end
        hz  = hv && ((e.ctrl[0] && pending(e.instr[15:11], b)) ||
                     (e.ctrl[1] && pending(e.instr[4:0], b)) ||
                     (e.ctrl[2] && pending(e.instr[20:16], b)));
        iss = hv && !hz && !b && !f;
        rdy = fifo.size() < FD && !f;
        psh = v && rdy;
        check("ready", ready, rdy);
        check("level", level, fifo.size());
        check("stall", stall, hz);
        check("wb_valid", wb_v, wi >= 0 && !b);
        check("issue_valid", iss_v, s0);
        check("issue_instr", iss_instr, last_instr);
        check("idle", idle, fifo.size() == 0 && fly.size() == 0);
        if (wi >= 0) begin
            check("wb_regd", wb_rd, fly[wi].rd);
            check("wb_regwr", wb_wr, fly[wi].wr);
        end
        @(posedge clk);
        cyc++;
        if (!b) begin
            if (wi >= 0) fly.delete(wi);
            foreach (fly[i]) fly[i].age++;
        end
        if (iss) begin
            fly.push_back('{rd: e.instr[20:16], wr: e.ctrl[2], age: 0});
            last_instr = e.instr;
            void'(fifo.pop_front());
        end
        if (f) fifo.delete();
        if (psh) fifo.push_back('{instr: ins, ctrl: c});
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_issue_valid", iss_v, 0);
        check("rst_issue_instr", iss_instr, 0);
        check("rst_wb_valid", wb_v, 0);
        check("rst_wb_regd", wb_rd, 0);
        check("rst_level", level, 0);
        check("rst_ready", ready, 1);
        check("rst_stall", stall, 0);
        check("rst_idle", idle, 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        quiet(3);
        // four independent writers back-to-back
        for (int i = 1; i <= 4; i++) step(1'b1, mk(i, 0, 0), 3'b100, 1'b0, 1'b0);
        quiet(8);
        // producer writes r5, consumer reads r5
        step(1'b1, mk(5, 0, 0), 3'b100, 1'b0, 1'b0);
        step(1'b1, mk(6, 5, 0), 3'b101, 1'b0, 1'b0);
        quiet(8);
        // fill while busy; fifth push refused until a pop frees space
        for (int i = 0; i < 5; i++) step(1'b1, mk(8 + i, 0, 0), 3'b100, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, mk(13, 0, 0), 3'b100, 1'b0, 1'b0);
        quiet(10);
        // writer to r7 frozen by busy, then released
        step(1'b1, mk(7, 0, 0), 3'b100, 1'b0, 1'b0);
        quiet(2);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        quiet(5);
        // flush with instructions queued and in flight
        step(1'b1, mk(1, 0, 0), 3'b100, 1'b0, 1'b0);
        step(1'b1, mk(2, 0, 0), 3'b100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, mk(20 + i, 0, 0), 3'b100, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        quiet(8);
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 9) < 7, mk($urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7)), 3'($urandom), $urandom_range(0, 9) < 2,
                 $urandom_range(0, 24) == 0);
            if (n == 700) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs();
                model_reset();
                vld = 1'b0; busy = 1'b0; flush = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk) rst_n = 1'b1;
                quiet(3);
            end
        end
        quiet(12);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
